instr_decode_queue: RTL and testbench
=====================================

// Module: instr_decode_queue
// PURPOSE
//  Buffered instruction register plus field decoder; replaces the level-enabled latch-style decoder.
//  Accepts fetched instruction words over a valid/ready handshake into a DEPTH-entry FIFO.
//  Moves the FIFO head into a registered decode stage and presents the split fields to control/regfile.
//  Field widths are parametrised; adds flush and a retired-instruction counter.
// PARAMETERS
//  INSTR_W   16  instruction word width
//  OPCODE_W  4   opcode field width, taken from the MSBs
//  REG_W     2   width of each register specifier (rs, rt, rd)
//  IMM_W     8   immediate field width, taken from the LSBs
//  DATA_W    16  width of the extended immediate; must be >= IMM_W
//  DEPTH     4   FIFO entries; power of 2, >= 2
//  CNT_W     16  width of the retired-instruction counter
// PORTS
//  clk          in   1         rising-edge clock
//  reset        in   1         synchronous, active-high reset
//  flush        in   1         synchronous discard of all queued and staged instructions
//  in_valid     in   1         instruction word valid
//  in_ready     out  1         queue can accept a word; equals !full
//  instruction  in   INSTR_W   instruction word
//  out_valid    out  1         decoded fields valid
//  out_ready    in   1         consumer accepts the decoded fields
//  opcode       out  OPCODE_W  instruction[INSTR_W-1 -: OPCODE_W]
//  rs           out  REG_W     next REG_W bits below opcode
//  rt           out  REG_W     next REG_W bits below rs
//  rd           out  REG_W     next REG_W bits below rt
//  target_address out INSTR_W-OPCODE_W  instruction[INSTR_W-OPCODE_W-1:0]
//  immediate    out  IMM_W     instruction[IMM_W-1:0]
//  imm_ext      out  DATA_W    immediate extended to DATA_W (see CONFIGURATION)
//  fill_level   out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
//  retired_cnt  out  CNT_W     count of handshakes where out_valid && out_ready
// BEHAVIOUR
//  - Reset: FIFO empty, fill_level=0, in_ready=1, out_valid=0, all field outputs 0, retired_cnt=0.
//  - Elaboration check: OPCODE_W + 3*REG_W <= INSTR_W and IMM_W <= DATA_W; otherwise $error.
//  - Enqueue: a word is written on each edge where in_valid && in_ready && !flush.
//  - Stage load: the decode register loads the FIFO head on any edge where the FIFO is non-empty
//    and (!out_valid || out_ready). out_valid is set on that edge.
//  - Stage empty: out_valid clears on an edge where out_valid && out_ready and the FIFO is empty.
//  - Latency: a word accepted at edge N shows on the outputs with out_valid=1 after edge N+1.
//    This holds when the FIFO was empty and the stage was free or draining. No same-cycle bypass.
//  - Throughput: 1 instruction/cycle sustained when out_ready is held high.
//  - Stall: while out_valid && !out_ready, every field output and out_valid stay stable.
//  - Full: when fill_level == DEPTH, in_ready=0.
//    A simultaneous dequeue at the full boundary does not raise in_ready combinationally.
//    in_ready is recomputed from registered state only.
//  - Simultaneous enqueue and dequeue: fill_level is unchanged; read/write pointers wrap modulo DEPTH.
//  - Flush (priority below reset): on the next edge the FIFO empties, out_valid=0, fill_level=0.
//    A same-cycle in_valid word is dropped.
//    A same-cycle out_valid && out_ready handshake still counts in retired_cnt.
//    Field outputs hold their last values, which are don't-care while out_valid=0.
//  - Reset mid-operation: discards everything, equivalent to flush, and also zeroes retired_cnt and the fields.
//  - retired_cnt increments by 1 per output handshake and wraps from 2^CNT_W-1 to 0.
//  - Field extraction is pure bit-slicing of the staged word; no opcode legality checking in this block.
// CONFIGURATION
//  IMM_SIGN_EXT_EN defined:   imm_ext = {{(DATA_W-IMM_W){immediate[IMM_W-1]}}, immediate}.
//  IMM_SIGN_EXT_EN undefined: imm_ext = {{(DATA_W-IMM_W){1'b0}}, immediate}.
//  All other behaviour is identical in both builds.
// TESTING
//  1. Reset, then 0x1A5F with out_ready=1 -> after 2 edges: opcode=1, rs=2, rt=2, rd=1,
//     immediate=0x5F, target_address=0xA5F, out_valid=1.
//  2. out_ready=0, push 5 words (DEPTH=4) -> 4 enter the FIFO plus staged handling as specified;
//     in_ready=0 at fill_level=4; outputs stable. Then out_ready=1 -> words exit in order, one per cycle, none lost.
//  3. Continuous in_valid/out_ready=1 for 100 words -> 100 in-order outputs; retired_cnt=100;
//     fill_level never exceeds 1.
//  4. flush asserted with fill_level=3 and in_valid=1 -> next edge: fill_level=0, out_valid=0,
//     in_ready=1, the flushed-cycle word never appears.
//  5. Immediate 0x85, DATA_W=16 -> imm_ext=0xFF85 with IMM_SIGN_EXT_EN, 0x0085 without.
//  6. CNT_W=4, 17 handshakes -> retired_cnt=1 (wrap); assert reset mid-stream -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/instr_decode_queue.sv
// instr_decode_queue: valid/ready instruction FIFO feeding a registered field-decode stage
// Optional feature macro: IMM_SIGN_EXT_EN (sign-extend imm_ext; zero-extend when undefined)
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   flush                discard all queued and staged instructions
//   in_valid/in_ready    instruction word handshake (in_ready = !full, registered state only)
//   instruction          fetched instruction word
//   out_valid/out_ready  decoded-field handshake
//   opcode, rs, rt, rd   fields sliced from the MSB end of the staged word
//   target_address       staged word below the opcode
//   immediate, imm_ext   low IMM_W bits, and that value extended to DATA_W
//   fill_level           FIFO occupancy 0..DEPTH
//   retired_cnt          wrapping count of output handshakes
module instr_decode_queue #(
    parameter int INSTR_W  = 16,
    parameter int OPCODE_W = 4,
    parameter int REG_W    = 2,
    parameter int IMM_W    = 8,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INSTR_W-1:0]          instruction,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OPCODE_W-1:0]         opcode,
    output logic [REG_W-1:0]            rs,
    output logic [REG_W-1:0]            rt,
    output logic [REG_W-1:0]            rd,
    output logic [INSTR_W-OPCODE_W-1:0] target_address,
    output logic [IMM_W-1:0]            immediate,
    output logic [DATA_W-1:0]           imm_ext,
    output logic [$clog2(DEPTH):0]      fill_level,
    output logic [CNT_W-1:0]            retired_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (OPCODE_W + 3 * REG_W > INSTR_W || IMM_W > DATA_W) begin : g_bad_params
        $error("instr_decode_queue: field widths do not fit INSTR_W/DATA_W");
    end

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [INSTR_W-1:0] stage;
    logic               push, pop;

    assign in_ready = fill_level != LW'(DEPTH);
    assign push     = in_valid && in_ready && !flush;
    // Stage refills whenever it is empty or being drained this cycle
    assign pop      = fill_level != '0 && (!out_valid || out_ready);

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= instruction;

    always_ff @(posedge clk) begin
        if (reset) begin
            {wr_ptr, rd_ptr, fill_level, out_valid, stage, retired_cnt} <= '0;
        end else begin
            if (out_valid && out_ready) retired_cnt <= retired_cnt + 1'b1;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fill_level <= '0;
                out_valid  <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    stage  <= mem[rd_ptr];
                end
                out_valid  <= pop || (out_valid && !out_ready);
                fill_level <= fill_level + LW'(push) - LW'(pop);
            end
        end
    end

    assign opcode         = stage[INSTR_W-1 -: OPCODE_W];
    assign rs             = stage[INSTR_W-OPCODE_W-1 -: REG_W];
    assign rt             = stage[INSTR_W-OPCODE_W-REG_W-1 -: REG_W];
    assign rd             = stage[INSTR_W-OPCODE_W-2*REG_W-1 -: REG_W];
    assign target_address = stage[INSTR_W-OPCODE_W-1:0];
    assign immediate      = stage[IMM_W-1:0];
`ifdef IMM_SIGN_EXT_EN
    assign imm_ext        = DATA_W'($signed(immediate));
`else
    assign imm_ext        = DATA_W'(immediate);
`endif
endmodule

// File: tb/tb_instr_decode_queue.sv
// tb_instr_decode_queue: directed vector bench for instr_decode_queue
module tb_instr_decode_queue;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [15:0] instruction;
    logic        in_ready, out_valid;
    logic [3:0]  opcode;
    logic [1:0]  rs, rt, rd;
    logic [11:0] target_address;
    logic [7:0]  immediate;
    logic [15:0] imm_ext;
    logic [2:0]  fill_level;
    logic [15:0] retired_cnt;

    logic        in_ready4, out_valid4;
    logic [3:0]  opcode4;
    logic [1:0]  rs4, rt4, rd4;
    logic [11:0] target_address4;
    logic [7:0]  immediate4;
    logic [15:0] imm_ext4;
    logic [2:0]  fill_level4;
    logic [3:0]  retired_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_decode_queue dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .target_address(target_address),
        .immediate(immediate), .imm_ext(imm_ext), .fill_level(fill_level),
        .retired_cnt(retired_cnt)
    );

    instr_decode_queue #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .instruction(instruction), .out_valid(out_valid4), .out_ready(out_ready),
        .opcode(opcode4), .rs(rs4), .rt(rt4), .rd(rd4), .target_address(target_address4),
        .immediate(immediate4), .imm_ext(imm_ext4), .fill_level(fill_level4),
        .retired_cnt(retired_cnt4)
    );

    typedef struct {
        logic [15:0] ins;
        logic [3:0]  op;
        logic [1:0]  rs, rt, rd;
        logic [11:0] tgt;
        logic [7:0]  imm;
        logic [15:0] ext_s, ext_z;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t vecs[6];
        logic [15:0] w[6];
        logic [15:0] exp_ext;
        int max_fill;
        vecs[0] = '{16'h1A5F, 4'h1, 2'd2, 2'd2, 2'd1, 12'hA5F, 8'h5F, 16'h005F, 16'h005F};
        vecs[1] = '{16'hF085, 4'hF, 2'd0, 2'd0, 2'd2, 12'h085, 8'h85, 16'hFF85, 16'h0085};
        vecs[2] = '{16'h3C3C, 4'h3, 2'd3, 2'd0, 2'd0, 12'hC3C, 8'h3C, 16'h003C, 16'h003C};
        vecs[3] = '{16'h76E1, 4'h7, 2'd1, 2'd2, 2'd3, 12'h6E1, 8'hE1, 16'hFFE1, 16'h00E1};
        vecs[4] = '{16'h0000, 4'h0, 2'd0, 2'd0, 2'd0, 12'h000, 8'h00, 16'h0000, 16'h0000};
        vecs[5] = '{16'hFFFF, 4'hF, 2'd3, 2'd3, 2'd3, 12'hFFF, 8'hFF, 16'hFFFF, 16'h00FF};

        reset = 1; flush = 0; in_valid = 0; out_ready = 0; instruction = '0;
        step(); step();
        reset = 0;
        check("rst_fill", fill_level, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_opcode", opcode, 0);
        check("rst_imm_ext", imm_ext, 0);
        check("rst_retired", retired_cnt, 0);

        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
`ifdef IMM_SIGN_EXT_EN
            exp_ext = vecs[i].ext_s;
`else
            exp_ext = vecs[i].ext_z;
`endif
            in_valid = 1; instruction = vecs[i].ins;
            step();
            in_valid = 0;
            check("vec_fill_n", fill_level, 1);
            check("vec_no_bypass", out_valid, 0);
            step();
            check("vec_out_valid", out_valid, 1);
            check("vec_opcode", opcode, vecs[i].op);
            check("vec_rs", rs, vecs[i].rs);
            check("vec_rt", rt, vecs[i].rt);
            check("vec_rd", rd, vecs[i].rd);
            check("vec_target", target_address, vecs[i].tgt);
            check("vec_imm", immediate, vecs[i].imm);
            check("vec_imm_ext", imm_ext, exp_ext);
        end
        step();
        check("vec_retired", retired_cnt, 6);
        check("vec_drained", out_valid, 0);

        // Stall and full boundary: 1 staged + 4 queued
        for (int i = 0; i < 6; i++) w[i] = 16'h8A00 + 16'(i);
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; instruction = w[i];
            step();
        end
        check("full_fill", fill_level, 4);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_head", target_address, 12'hA00);
        instruction = w[5];
        step();
        check("stall_fill", fill_level, 4);
        check("stall_head", target_address, 12'hA00);
        check("stall_valid", out_valid, 1);
        out_ready = 1;
        step();
        in_valid = 0;
        check("full_deq_fill", fill_level, 3);
        check("full_deq_head", target_address, 12'hA01);
        for (int i = 2; i < 5; i++) begin
            step();
            check("drain_order", target_address, 12'hA00 + 12'(i));
            check("drain_fill", fill_level, 3'(4 - i));
        end
        step();
        check("drain_empty", out_valid, 0);
        check("drain_retired", retired_cnt, 11);

        // Sustained throughput
        max_fill = 0;
        for (int k = 0; k < 102; k++) begin
            in_valid = k < 100; instruction = {4'h5, 12'(k)};
            step();
            if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
            if (k >= 1 && k <= 100) begin
                check("tp_valid", out_valid, 1);
                check("tp_order", target_address, 12'(k - 1));
            end
        end
        in_valid = 0;
        check("tp_max_fill", max_fill, 1);
        check("tp_empty", out_valid, 0);
        check("tp_retired", retired_cnt, 111);
        check("tp_retired_w4", retired_cnt4, 15);

        // Flush with fill_level=3, a same-cycle word and a same-cycle handshake
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; instruction = 16'h4100 + 16'(i);
            step();
        end
        check("pre_flush_fill", fill_level, 3);
        flush = 1; in_valid = 1; instruction = 16'hDEAD; out_ready = 1;
        step();
        flush = 0; in_valid = 0;
        check("flush_fill", fill_level, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_retired", retired_cnt, 112);
        check("flush_retired_wrap", retired_cnt4, 0);
        step(); step();
        check("flush_dropped", out_valid, 0);
        check("flush_dropped_fill", fill_level, 0);
        in_valid = 1; instruction = 16'h2BCD;
        step();
        in_valid = 0; out_ready = 0;
        step();
        check("post_flush_valid", out_valid, 1);
        check("post_flush_target", target_address, 12'hBCD);

        // Reset mid-stream
        in_valid = 1; instruction = 16'h9999;
        step();
        check("pre_rst_fill", fill_level, 1);
        reset = 1;
        step();
        reset = 0; in_valid = 0;
        check("mid_rst_fill", fill_level, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_opcode", opcode, 0);
        check("mid_rst_target", target_address, 0);
        check("mid_rst_imm_ext", imm_ext, 0);
        check("mid_rst_retired", retired_cnt, 0);
        check("mid_rst_retired4", retired_cnt4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
